mem_store_narrow: RTL and testbench
===================================

# mem_store_narrow

MEM-stage store unit of the MIPS pipeline: the inverse of the decode-stage sign extender. It takes a full 32-bit register value and narrows it to the byte, halfword or word selected by the store opcode, steering it onto big-endian byte lanes with byte enables. It presents the result to data memory under a req/ack handshake, back-pressures the EX/MEM register while memory is busy, flags address-error stores (AdES) and counts completed stores.

## Interface
Parameters:
- CNT_W, 16, width of completed-store counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- st_valid  in  1  EX/MEM holds a store (sb/sh/sw)
- st_ready  out  1  unit accepts the store this cycle; EX/MEM stalls when st_valid & ~st_ready
- st_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- st_addr  in  32  effective byte address from ALU
- st_data  in  32  rt register value
- mem_req  out  1  write request to data memory
- mem_ack  in  1  memory accepted the write this cycle
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_wdata  out  32  lane-steered write data
- mem_be  out  4  byte enables; be[3] = bits [31:24] = byte offset 0
- st_exc  out  1  one-cycle AdES pulse
- st_exc_addr  out  32  faulting address (BadVAddr)
- st_count  out  CNT_W  completed stores, wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, REQ.
- st_ready = (state==IDLE) | (state==REQ & mem_ack). This is combinational from state and mem_ack.
- Accept = st_valid & st_ready at a rising edge.
- Illegal store: size 11; halfword with addr[0]=1; word with addr[1:0]!=0.
  - Effect: st_exc=1 for exactly the next cycle and st_exc_addr<=st_addr.
  - No mem_req is issued. State goes to IDLE (from REQ only if mem_ack completed the old request).
- Legal accepted store: go to (or stay in) REQ with mem_req=1.
  - mem_addr<={st_addr[31:2],2'b00}.
  - Byte: mem_wdata={4{st_data[7:0]}}, mem_be=4'b1000>>addr[1:0].
  - Halfword: mem_wdata={2{st_data[15:0]}}, mem_be=addr[1]?4'b0011:4'b1100.
  - Word: mem_wdata=st_data, mem_be=4'b1111.
- REQ & ~mem_ack: all mem_* outputs hold stable, st_ready=0.
- REQ & mem_ack & no accept: state<=IDLE, mem_req<=0. mem_addr/wdata/be keep their last values.
- st_count increments by 1 on every cycle with mem_req & mem_ack, and wraps to 0 past all-ones.
- Simultaneous ack + new accept: the old store completes and is counted, and the new store is loaded in the same edge. mem_req stays 1, giving a throughput of one store per cycle.
- st_valid while in IDLE with mem_ack high is ignored for completion; there is no count without mem_req.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - st_exc=0, st_exc_addr=0, st_count=0.
  - st_ready=1.
- Reset asserted mid-REQ: mem_req drops immediately and the pending store is discarded, not counted.
- Latency: accept at edge N means mem_req/addr/wdata/be are valid after N. Earliest completion is ack at edge N+1.
- Illegal accept at edge N means st_exc is high during cycle N..N+1 only.
- No combinational path from st_* inputs to mem_* outputs. The only combinational paths are mem_ack to st_ready and state to st_ready.

## Test plan
- sb, addr=0x1003, data=0xDEADBE5A, ack next cycle -> mem_addr=0x1000, mem_wdata=0x5A5A5A5A, mem_be=0001, st_count=1.
- sh, addr=0x2002, data=0x0000BEEF; then sw, addr=0x3000, data=0x12345678, presented while ack is high -> first store mem_be=0011, wdata=0xBEEFBEEF. The second loads on the same edge with mem_req continuous, wdata=0x12345678, be=1111, and st_count reaches 2 after its ack.
- sw, addr=0x4002 -> no mem_req, st_exc pulses one cycle, st_exc_addr=0x00004002. Repeat with sh addr=0x4001 and with size=11 -> same response.
- Store accepted, mem_ack held low 5 cycles -> st_ready=0 and mem_* outputs bit-stable for 5 cycles. Ack on the 6th cycle -> mem_req low next cycle, count +1.
- Assert rst_n low while in REQ, between clock edges -> mem_req and all outputs go to 0 immediately, st_ready=1, st_count=0.
- CNT_W=4 with 17 back-to-back acked stores -> st_count wraps to 1.

Source files
------------

// File: rtl/mem_store_narrow.sv
// mem_store_narrow: MEM-stage store unit, narrows rt to byte/half/word lanes and writes data memory via req/ack
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   st_valid/st_ready     store handshake from EX/MEM (ready is combinational from state and mem_ack)
//   st_size/addr/data     00 byte, 01 half, 10 word, 11 illegal; byte address; rt value
//   mem_req/mem_ack       write request to data memory, accepted when both high
//   mem_addr/wdata/be     word address, lane-steered data, big-endian byte enables (be[3] = offset 0)
//   st_exc/st_exc_addr    one-cycle AdES pulse and faulting address
//   st_count              completed stores, wraps modulo 2^CNT_W
module mem_store_narrow #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [1:0]       st_size,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    output logic             mem_req,
    input  logic             mem_ack,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    output logic             st_exc,
    output logic [31:0]      st_exc_addr,
    output logic [CNT_W-1:0] st_count
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t             state_q, state_d;
    logic [31:0]        mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [31:0]        st_exc_addr_q, st_exc_addr_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic               st_exc_q, st_exc_d;
    logic [CNT_W-1:0]   st_count_q, st_count_d;
    logic               accept, illegal, done;

    assign st_ready = (state_q == IDLE) | ((state_q == REQ) & mem_ack);
    assign accept   = st_valid & st_ready;
    assign done     = (state_q == REQ) & mem_ack;
    assign illegal  = (st_size == 2'b11) | ((st_size == 2'b01) & st_addr[0]) |
                      ((st_size == 2'b10) & (|st_addr[1:0]));

    // A new legal store overrides the completion of the old one, keeping mem_req high back to back.
    always_comb begin
        state_d       = done ? IDLE : state_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        st_exc_d      = accept & illegal;
        st_exc_addr_d = (accept & illegal) ? st_addr : st_exc_addr_q;
        st_count_d    = st_count_q + CNT_W'(done);
        if (accept && !illegal) begin
            state_d     = REQ;
            mem_addr_d  = {st_addr[31:2], 2'b00};
            mem_wdata_d = (st_size == 2'b00) ? {4{st_data[7:0]}} :
                          (st_size == 2'b01) ? {2{st_data[15:0]}} : st_data;
            mem_be_d    = (st_size == 2'b00) ? (4'b1000 >> st_addr[1:0]) :
                          (st_size == 2'b01) ? (st_addr[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            st_exc_q      <= 1'b0;
            st_exc_addr_q <= '0;
            st_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            st_exc_q      <= st_exc_d;
            st_exc_addr_q <= st_exc_addr_d;
            st_count_q    <= st_count_d;
        end
    end

    assign mem_req     = (state_q == REQ);
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_be      = mem_be_q;
    assign st_exc      = st_exc_q;
    assign st_exc_addr = st_exc_addr_q;
    assign st_count    = st_count_q;
endmodule

// File: tb/tb_mem_store_narrow.sv
// tb_mem_store_narrow: self-checking bench for mem_store_narrow (directed table, corner sequences, random vs model)
module tb_mem_store_narrow;
    logic        clk, rst_n, st_valid, mem_ack;
    logic [1:0]  st_size;
    logic [31:0] st_addr, st_data;
    logic        st_ready, mem_req, st_exc;
    logic [31:0] mem_addr, mem_wdata, st_exc_addr;
    logic [3:0]  mem_be;
    logic [15:0] st_count;
    logic        w4_ready, w4_req, w4_exc;
    logic [31:0] w4_addr, w4_wdata, w4_exc_addr;
    logic [3:0]  w4_be, w4_count;

    mem_store_narrow #(.CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready), .st_size(st_size),
        .st_addr(st_addr), .st_data(st_data), .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .st_exc(st_exc),
        .st_exc_addr(st_exc_addr), .st_count(st_count));

    mem_store_narrow #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(w4_ready), .st_size(st_size),
        .st_addr(st_addr), .st_data(st_data), .mem_req(w4_req), .mem_ack(mem_ack),
        .mem_addr(w4_addr), .mem_wdata(w4_wdata), .mem_be(w4_be), .st_exc(w4_exc),
        .st_exc_addr(w4_exc_addr), .st_count(w4_count));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the set of architecturally visible results, updated per clock from the store rules.
    logic        m_pend, m_exc;
    logic [31:0] m_ma, m_wd, m_ea;
    logic [3:0]  m_be;
    int          m_cnt;

    task automatic m_reset();
        m_pend = 0; m_exc = 0; m_ma = 0; m_wd = 0; m_ea = 0; m_be = 0; m_cnt = 0;
    endtask

    function automatic logic m_ready();
        return !m_pend || mem_ack;
    endfunction

    task automatic drive(input logic v, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input logic k);
        st_valid = v; st_size = sz; st_addr = a; st_data = d; mem_ack = k;
        #1;
    endtask

    task automatic tick();
        int nb, off;
        logic acc;
        acc = st_valid && m_ready();
        if (m_pend && mem_ack) begin
            m_cnt++;
            m_pend = 0;
        end
        m_exc = 0;
        if (acc) begin
            nb  = 1 << st_size;
            off = int'(st_addr[1:0]);
            if (st_size == 2'd3 || (st_addr % nb) != 0) begin
                m_exc = 1;
                m_ea  = st_addr;
            end else begin
                m_pend = 1;
                m_ma   = st_addr - 32'(off);
                m_wd   = (nb == 1) ? 32'(st_data[7:0]) * 32'h01010101 :
                         (nb == 2) ? 32'(st_data[15:0]) * 32'h00010001 : st_data;
                m_be   = 4'(((1 << nb) - 1) << (4 - off - nb));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".req"}, mem_req, m_pend);
        chk({tag, ".addr"}, mem_addr, m_ma);
        chk({tag, ".wdata"}, mem_wdata, m_wd);
        chk({tag, ".be"}, mem_be, m_be);
        chk({tag, ".exc"}, st_exc, m_exc);
        chk({tag, ".exc_addr"}, st_exc_addr, m_ea);
        chk({tag, ".count"}, st_count, 32'(m_cnt[15:0]));
        chk({tag, ".count4"}, w4_count, 32'(m_cnt[3:0]));
    endtask

    typedef struct {
        logic v; logic [1:0] sz; logic [31:0] a; logic [31:0] d; logic k;
        logic rdy; logic req; logic [31:0] ma; logic [31:0] wd; logic [3:0] be;
        logic exc; logic [31:0] ea; logic [15:0] cnt;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1, 2'd0, 32'h1003, 32'hDEADBE5A, 0, 1, 1, 32'h1000, 32'h5A5A5A5A, 4'b0001, 0, 32'h0, 16'd0};
        tbl[1]  = '{1, 2'd2, 32'h7000, 32'h99999999, 0, 0, 1, 32'h1000, 32'h5A5A5A5A, 4'b0001, 0, 32'h0, 16'd0};
        tbl[2]  = '{0, 2'd0, 32'h0,    32'h0,        1, 1, 0, 32'h1000, 32'h5A5A5A5A, 4'b0001, 0, 32'h0, 16'd1};
        tbl[3]  = '{1, 2'd1, 32'h2002, 32'h0000BEEF, 0, 1, 1, 32'h2000, 32'hBEEFBEEF, 4'b0011, 0, 32'h0, 16'd1};
        tbl[4]  = '{1, 2'd2, 32'h3000, 32'h12345678, 1, 1, 1, 32'h3000, 32'h12345678, 4'b1111, 0, 32'h0, 16'd2};
        tbl[5]  = '{0, 2'd0, 32'h0,    32'h0,        1, 1, 0, 32'h3000, 32'h12345678, 4'b1111, 0, 32'h0, 16'd3};
        tbl[6]  = '{1, 2'd2, 32'h4002, 32'h11111111, 0, 1, 0, 32'h3000, 32'h12345678, 4'b1111, 1, 32'h4002, 16'd3};
        tbl[7]  = '{1, 2'd1, 32'h4001, 32'h22222222, 0, 1, 0, 32'h3000, 32'h12345678, 4'b1111, 1, 32'h4001, 16'd3};
        tbl[8]  = '{1, 2'd3, 32'h4000, 32'h33333333, 0, 1, 0, 32'h3000, 32'h12345678, 4'b1111, 1, 32'h4000, 16'd3};
        tbl[9]  = '{0, 2'd0, 32'h0,    32'h0,        0, 1, 0, 32'h3000, 32'h12345678, 4'b1111, 0, 32'h4000, 16'd3};
        tbl[10] = '{0, 2'd0, 32'h5,    32'h0,        1, 1, 0, 32'h3000, 32'h12345678, 4'b1111, 0, 32'h4000, 16'd3};

        rst_n = 0;
        drive(0, 0, 0, 0, 0);
        m_reset();
        repeat (2) @(negedge clk);
        chk("reset.ready", st_ready, 1);
        cmp_model("reset");
        rst_n = 1;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].sz, tbl[i].a, tbl[i].d, tbl[i].k);
            chk($sformatf("vec%0d.ready", i), st_ready, tbl[i].rdy);
            tick();
            chk($sformatf("vec%0d.req", i), mem_req, tbl[i].req);
            chk($sformatf("vec%0d.addr", i), mem_addr, tbl[i].ma);
            chk($sformatf("vec%0d.wdata", i), mem_wdata, tbl[i].wd);
            chk($sformatf("vec%0d.be", i), mem_be, tbl[i].be);
            chk($sformatf("vec%0d.exc", i), st_exc, tbl[i].exc);
            chk($sformatf("vec%0d.exc_addr", i), st_exc_addr, tbl[i].ea);
            chk($sformatf("vec%0d.count", i), st_count, tbl[i].cnt);
        end

        // Five stalled cycles with a competing store presented, then ack.
        drive(1, 2, 32'h5000, 32'hA5A5F00D, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 32'h6001, 32'hFFFFFFFF, 0);
            chk("stall.ready", st_ready, 0);
            tick();
            chk("stall.req", mem_req, 1);
            chk("stall.addr", mem_addr, 32'h5000);
            chk("stall.wdata", mem_wdata, 32'hA5A5F00D);
            chk("stall.be", mem_be, 4'b1111);
        end
        drive(0, 0, 0, 0, 1);
        chk("stall_ack.ready", st_ready, 1);
        tick();
        chk("stall_ack.req", mem_req, 0);
        chk("stall_ack.count", st_count, 16'd4);
        cmp_model("stall_ack");

        // Asynchronous reset between edges while a request is pending.
        drive(1, 0, 32'h8002, 32'h000000C3, 0);
        tick();
        chk("pre_rst.req", mem_req, 1);
        #2 rst_n = 0;
        #1;
        chk("rst.req", mem_req, 0);
        chk("rst.addr", mem_addr, 0);
        chk("rst.wdata", mem_wdata, 0);
        chk("rst.be", mem_be, 0);
        chk("rst.ready", st_ready, 1);
        chk("rst.count", st_count, 0);
        chk("rst.exc_addr", st_exc_addr, 0);
        m_reset();
        @(negedge clk);
        rst_n = 1;

        // 17 back-to-back acknowledged stores: 4-bit counter wraps to 1.
        drive(1, 2, 32'h0, 32'h0, 0);
        tick();
        for (int i = 1; i < 17; i++) begin
            drive(1, 2, 32'(i * 4), 32'(i), 1);
            chk("b2b.ready", st_ready, 1);
            tick();
            chk("b2b.req", mem_req, 1);
        end
        drive(0, 0, 0, 0, 1);
        tick();
        chk("wrap.count4", w4_count, 4'd1);
        chk("wrap.count", st_count, 16'd17);
        cmp_model("wrap");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), a, $urandom,
                  1'($urandom_range(0, 9) < 6));
            chk("rnd.ready", st_ready, m_ready());
            tick();
            cmp_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
